vgm_apb_slave_regfile: RTL and testbench

VGM_APB_SLAVE_REGFILE -- requirements
Module: vgm_apb_slave_regfile

---
 rtl/vgm_apb_slave_pkg.sv | 34 +++
 rtl/vgm_apb_slave_ctrl.sv | 122 ++++++++++++
 rtl/vgm_apb_slave_regfile.sv | 101 ++++++++++
 tb/tb_vgm_apb_slave_regfile.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgm_apb_slave_pkg.sv
// Purpose : shared types and constants for the APB slave register file.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: the APB phase-tracking FSM state enum, the bus data and address
// widths, the wait-counter width, and small helpers for the word-index decode.
// Used with the optional macro VGM_APB_SLVERR_EN (see vgm_apb_slave_regfile).
package vgm_apb_slave_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int WAIT_W = 4;
  localparam int IDX_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef logic [WAIT_W-1:0] wait_cnt_t;
  typedef logic [IDX_W-1:0]  word_idx_t;

  // Word index of a byte address; the two byte-lane bits carry no meaning.
  function automatic word_idx_t word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  // A word index hits the register array when it is below the register count.
  function automatic logic idx_mapped(input word_idx_t idx, input int num_regs);
    return idx < IDX_W'(num_regs);
  endfunction

endpackage

// File: rtl/vgm_apb_slave_ctrl.sv
// Purpose : APB transfer control - phase FSM, wait-state counter, address/data capture, protocol checking.
// Latency : SETUP state, then WAIT_STATES ACCESS cycles with pready low, then one ACCESS cycle with pready high.
// Backpressure: pready held low while the wait counter is nonzero; the requester must hold PSEL/PENABLE/PADDR/PWRITE/PWDATA.
//
// Ports:
//   PCLK, PRESET           clock, asynchronous active-high reset
//   psel, penable          APB select / enable from the requester
//   paddr, pwrite, pwdata  APB address, direction, write data
//   pready                 transfer complete (ACCESS with wait counter at zero)
//   cap_idx                captured word index (PADDR[31:2])
//   cap_write, cap_wdata   captured direction and write data
//   proto_err              sticky protocol-violation flag
module vgm_apb_slave_ctrl
  import vgm_apb_slave_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output word_idx_t         cap_idx,
  output logic              cap_write,
  output logic [DATA_W-1:0] cap_wdata,
  output logic              proto_err
);

  localparam wait_cnt_t WAIT_INIT = WAIT_W'(WAIT_STATES);

  apb_state_e        state_q;
  apb_state_e        state_d;
  wait_cnt_t         wait_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_set;
  logic              bus_changed;

  assign pready  = (state_q == ACCESS) && (wait_q == '0);
  assign cap_idx = word_index(addr_q);

  // Full-width compare: the byte-lane bits are still part of the held address.
  assign bus_changed = (paddr != addr_q) || (pwrite != cap_write) ||
                       (pwdata != cap_wdata);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (penable) begin
          err_set = 1'b1;
        end else if (psel) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          // The completing cycle may already carry the next setup phase, so
          // a new address here is legal and starts a back-to-back transfer.
          state_d = (psel && !penable) ? SETUP : IDLE;
        end else if (!psel || !penable) begin
          // Requester abandoned the transfer: drop it without a write.
          err_set = 1'b1;
          state_d = IDLE;
        end else if (bus_changed) begin
          // Flag only; the transfer carries on with the captured values.
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_q <= '0;
    end else if (state_q == SETUP) begin
      wait_q <= WAIT_INIT;
    end else if ((state_q == ACCESS) && (wait_q != '0)) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  // Request fields are taken while the FSM sits in SETUP; the requester is
  // required to keep them stable from then until completion.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q    <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if (state_q == SETUP) begin
      addr_q    <= paddr;
      cap_write <= pwrite;
      cap_wdata <= pwdata;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      proto_err <= 1'b0;
    end else if (err_set) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/vgm_apb_slave_regfile.sv
// Purpose : APB slave exposing NUM_REGS 32-bit read/write registers, all contents also visible on regs_q.
// Latency : WAIT_STATES+1 ACCESS-state cycles per transfer; a write shows on regs_q the cycle after PREADY.
// Backpressure: PREADY low during inserted wait states; requester holds the transfer until PREADY.
//
// Ports:
//   PCLK, PRESET     clock, asynchronous active-high reset
//   PSEL, PENABLE    APB select / access-phase indicator
//   PADDR            byte address, bits [1:0] ignored
//   PWRITE, PWDATA   direction (1 = write) and write data
//   PREADY, PRDATA   completion and read data (zero unless a mapped read completes)
//   PSLVERR          unmapped-access error, only when VGM_APB_SLVERR_EN is defined
//   regs_q           register i at bits [32*i+31:32*i]
//   proto_err        sticky APB protocol-violation flag
// Build option: define VGM_APB_SLVERR_EN to add the PSLVERR port.
module vgm_apb_slave_regfile
  import vgm_apb_slave_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic                       PWRITE,
  input  logic [DATA_W-1:0]          PWDATA,
  output logic                       PREADY,
  output logic [DATA_W-1:0]          PRDATA,
`ifdef VGM_APB_SLVERR_EN
  output logic                       PSLVERR,
`endif
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       proto_err
);

  word_idx_t         cap_idx;
  logic              cap_write;
  logic [DATA_W-1:0] cap_wdata;
  logic              mapped;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] regs [NUM_REGS];

  vgm_apb_slave_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_ctrl (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .psel      (PSEL),
    .penable   (PENABLE),
    .paddr     (PADDR),
    .pwrite    (PWRITE),
    .pwdata    (PWDATA),
    .pready    (PREADY),
    .cap_idx   (cap_idx),
    .cap_write (cap_write),
    .cap_wdata (cap_wdata),
    .proto_err (proto_err)
  );

  assign mapped = idx_mapped(cap_idx, NUM_REGS);
  assign wr_en  = PREADY && cap_write && mapped;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cap_idx == IDX_W'(i)) begin
          regs[i] <= cap_wdata;
        end
      end
    end
  end

  // Compare-based mux keeps every select in range for any NUM_REGS.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cap_idx == IDX_W'(i)) begin
        rd_word = regs[i];
      end
    end
  end

  assign PRDATA = (PREADY && !cap_write && mapped) ? rd_word : '0;

`ifdef VGM_APB_SLVERR_EN
  assign PSLVERR = PREADY && !mapped;
`else
  // No error response: unmapped reads return zero and unmapped writes are dropped.
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
    assign regs_q[DATA_W*g +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_vgm_apb_slave_regfile.sv
// Purpose : self-checking bench for vgm_apb_slave_regfile with a behavioural register model.
// Latency : expects WS wait cycles then PREADY per transfer.
// Backpressure: requester holds each transfer until PREADY, optionally chaining the next setup.
module tb_vgm_apb_slave_regfile;

  localparam int NREGS = 8;
  localparam int WS    = 3;

  logic                   PCLK = 1'b0;
  logic                   PRESET;
  logic                   PSEL;
  logic                   PENABLE;
  logic [31:0]            PADDR;
  logic                   PWRITE;
  logic [31:0]            PWDATA;
  logic                   PREADY;
  logic [31:0]            PRDATA;
`ifdef VGM_APB_SLVERR_EN
  logic                   PSLVERR;
`endif
  logic [NREGS*32-1:0]    regs_q;
  logic                   proto_err;

  always #5 PCLK = ~PCLK;

  vgm_apb_slave_regfile #(
    .NUM_REGS    (NREGS),
    .WAIT_STATES (WS)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
`ifdef VGM_APB_SLVERR_EN
    .PSLVERR   (PSLVERR),
`endif
    .regs_q    (regs_q),
    .proto_err (proto_err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [NREGS];
  logic [31:0] x_rdata;
  logic        x_slverr;
  int          x_waits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    step();
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), regs_q[32*i +: 32], model[i]);
    end
  endtask

  // Called right after a clock edge with the FSM able to accept a setup
  // phase (idle, or in the completing cycle of the previous transfer).
  // Returns in the completing cycle with PSEL/PENABLE still high.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PADDR   = addr;
    PWRITE  = wr;
    PWDATA  = wd;
    step();
    chk("setup_pready", {31'b0, PREADY}, 32'h0);
    PENABLE = 1'b1;
    step();
    x_waits = 0;
    while (PREADY !== 1'b1 && x_waits < 40) begin
      chk("wait_prdata", PRDATA, 32'h0);
      x_waits++;
      step();
    end
    x_rdata = PRDATA;
`ifdef VGM_APB_SLVERR_EN
    x_slverr = PSLVERR;
`else
    x_slverr = 1'b0;
`endif
  endtask

  task automatic xfer_chk(input string tag, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    int   idx;
    logic hit;
    idx = int'(addr >> 2);
    hit = (idx < NREGS);
    xfer(addr, wr, wd);
    chk({tag, "_waits"}, x_waits, WS);
    if (!wr) chk({tag, "_rdata"}, x_rdata, hit ? model[idx] : 32'h0);
`ifdef VGM_APB_SLVERR_EN
    chk({tag, "_slverr"}, {31'b0, x_slverr}, {31'b0, !hit});
`endif
    if (wr && hit) model[idx] = wd;
  endtask

  task automatic pulse_reset();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PRESET  = 1'b1;
    #1;
    chk("rst_proto_err", {31'b0, proto_err}, 32'h0);
    step();
    PRESET = 1'b0;
    model_clear();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d1;
    logic [31:0] d2;
    PRESET  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PADDR   = 32'h0;
    PWRITE  = 1'b0;
    PWDATA  = 32'h0;
    model_clear();
    step();
    step();
    chk("reset_pready", {31'b0, PREADY}, 32'h0);
    chk("reset_prdata", PRDATA, 32'h0);
    chk("reset_proto_err", {31'b0, proto_err}, 32'h0);
    check_regs("reset");
    PRESET = 1'b0;
    step();

    // Write then read back word 1.
    xfer_chk("wr04", 32'h04, 1'b1, 32'hDEADBEEF);
    bus_idle();
    chk("wr04_regs_q", regs_q[63:32], 32'hDEADBEEF);
    xfer_chk("rd04", 32'h04, 1'b0, 32'h0);
    bus_idle();

    // Read of a never-written register.
    xfer_chk("rd00", 32'h00, 1'b0, 32'h0);
    bus_idle();

    // Unmapped write and read leave the array untouched.
    xfer_chk("wr20", 32'h20, 1'b1, 32'h12345678);
    bus_idle();
    check_regs("unmapped");
    xfer_chk("rd24", 32'h24, 1'b0, 32'h0);
    bus_idle();

    // Back-to-back writes: second setup rides on the first completion cycle.
    xfer_chk("b2b0", 32'h00, 1'b1, 32'hA5A5_0001);
    xfer_chk("b2b1", 32'h1C, 1'b1, 32'h5A5A_0007);
    bus_idle();
    check_regs("b2b");
    chk("b2b_proto_err", {31'b0, proto_err}, 32'h0);

    // Write data changes mid-wait: flagged, captured data still written.
    d1 = 32'h1111_2222;
    d2 = 32'h3333_4444;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = d1;
    step();
    PENABLE = 1'b1;
    step();
    PWDATA = d2;
    step();
    chk("chg_proto_err", {31'b0, proto_err}, 32'h1);
    x_waits = 0;
    while (PREADY !== 1'b1 && x_waits < 40) begin
      x_waits++;
      step();
    end
    chk("chg_done", {31'b0, PREADY}, 32'h1);
    bus_idle();
    model[3] = d1;
    check_regs("chg");
    pulse_reset();

    // PENABLE high while idle sets the sticky flag; reset clears it.
    PENABLE = 1'b1;
    step();
    chk("idle_en_err", {31'b0, proto_err}, 32'h1);
    PENABLE = 1'b0;
    step();
    step();
    chk("idle_en_sticky", {31'b0, proto_err}, 32'h1);
    pulse_reset();
    chk("idle_en_cleared", {31'b0, proto_err}, 32'h0);

    // Requester drops PSEL mid-wait: flagged, no write, next transfer from idle.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h14; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    chk("drop_proto_err", {31'b0, proto_err}, 32'h1);
    chk("drop_pready", {31'b0, PREADY}, 32'h0);
    step();
    step();
    step();
    step();
    check_regs("drop");
    xfer_chk("drop_rd14", 32'h14, 1'b0, 32'h0);
    bus_idle();
    pulse_reset();

    // Reset in the middle of a write's wait phase.
    xfer_chk("pre_wr08", 32'h08, 1'b1, 32'h7777_8888);
    bus_idle();
    pulse_reset();
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'h9999_AAAA;
    step();
    PENABLE = 1'b1;
    step();
    step();
    PRESET = 1'b1;
    #1;
    chk("midrst_pready", {31'b0, PREADY}, 32'h0);
    chk("midrst_reg2", regs_q[95:64], 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    PRESET = 1'b0;
    model_clear();
    step();
    step();
    check_regs("midrst");
    xfer_chk("midrst_rd08", 32'h08, 1'b0, 32'h0);
    bus_idle();

    // Randomized traffic, mixing mapped/unmapped and chained/idle-separated.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, NREGS + 3)) << 2;
      a = a | 32'($urandom_range(0, 3));
      xfer_chk($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus_idle();
        check_regs($sformatf("rnd%0d", n));
      end
    end
    bus_idle();
    check_regs("rnd_end");
    chk("rnd_proto_err", {31'b0, proto_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
